// File: rtl/serial_pkg.sv
// Shared types and defaults for the serial adder front end.
package serial_pkg;

    localparam int DEFAULT_WIDTH        = 4;
    localparam int DEFAULT_DRAIN_CYCLES = 2;

    // Drain counter width; enough for the 0..7 drain range.
    localparam int DRAIN_CNT_W = 3;

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        SHIFT,
        DRAIN,
        DONE
    } state_e;

    // Bit-index width: $clog2(width), but never narrower than one bit.
    function automatic int idx_width(input int width);
        return (width > 1) ? $clog2(width) : 1;
    endfunction

endpackage

// File: rtl/serial_shift_reg.sv
// Parallel-load, shift-right operand register; the LSB is the serial bit on offer.
module serial_shift_reg
    import serial_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             shift,
    input  logic             clear,
    input  logic [WIDTH-1:0] din,
    output logic             lsb
);

    logic [WIDTH-1:0] data_q;
    logic [WIDTH-1:0] data_d;

    // Load wins over clear, clear wins over shift; otherwise hold.
    always_comb begin
        data_d = data_q;
        if (load) begin
            data_d = din;
        end else if (clear) begin
            data_d = '0;
        end else if (shift) begin
            data_d = data_q >> 1;
        end
    end

    // Operand storage; reset discards any latched operand.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_q <= '0;
        end else begin
            data_q <= data_d;
        end
    end

    assign lsb = data_q[0];

endmodule

// File: rtl/serial_operand_feeder.sv
// Accepts parallel operands and streams them LSB-first into the serial adder.
module serial_operand_feeder
    import serial_pkg::*;
#(
    parameter  int WIDTH        = DEFAULT_WIDTH,
    parameter  int DRAIN_CYCLES = DEFAULT_DRAIN_CYCLES,
    localparam int IDX_W        = idx_width(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_cin,
    output logic             ser_rst,
    output logic             ser_a,
    output logic             ser_b,
    output logic             ser_cin,
    output logic             ser_first,
    output logic             ser_last,
    output logic [IDX_W-1:0] bit_idx,
    output logic             busy,
    output logic             done
);

    localparam logic [IDX_W-1:0]       LAST_IDX   = IDX_W'(WIDTH - 1);
    localparam logic [DRAIN_CNT_W-1:0] DRAIN_LOAD =
        (DRAIN_CYCLES > 0) ? DRAIN_CNT_W'(DRAIN_CYCLES - 1) : '0;

    state_e                 state_q, state_d;
    logic [DRAIN_CNT_W-1:0] drain_cnt_q, drain_cnt_d;
    logic [IDX_W-1:0]       bit_idx_q, bit_idx_d;
    logic                   ser_rst_q, ser_rst_d;
    logic                   ser_a_q, ser_a_d;
    logic                   ser_b_q, ser_b_d;
    logic                   ser_cin_q, ser_cin_d;
    logic                   ser_first_q, ser_first_d;
    logic                   ser_last_q, ser_last_d;
    logic                   busy_q, busy_d;
    logic                   done_q, done_d;

    logic accept;
    logic sr_load;
    logic sr_shift;
    logic sr_clear;
    logic sr_a_lsb;
    logic sr_b_lsb;

    assign in_ready = (state_q == IDLE) && !flush;
    assign accept   = in_valid && in_ready;

    serial_shift_reg #(.WIDTH(WIDTH)) u_shift_a (
        .clk   (clk),
        .rst   (rst),
        .load  (sr_load),
        .shift (sr_shift),
        .clear (sr_clear),
        .din   (in_a),
        .lsb   (sr_a_lsb)
    );

    serial_shift_reg #(.WIDTH(WIDTH)) u_shift_b (
        .clk   (clk),
        .rst   (rst),
        .load  (sr_load),
        .shift (sr_shift),
        .clear (sr_clear),
        .din   (in_b),
        .lsb   (sr_b_lsb)
    );

    // Next state, then every registered output decoded from the state being entered.
    always_comb begin
        state_d     = state_q;
        drain_cnt_d = drain_cnt_q;

        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = CLEAR;
                end
            end
            CLEAR: begin
                state_d = SHIFT;
            end
            SHIFT: begin
                if (bit_idx_q == LAST_IDX) begin
                    if (DRAIN_CYCLES == 0) begin
                        state_d = DONE;
                    end else begin
                        state_d     = DRAIN;
                        drain_cnt_d = DRAIN_LOAD;
                    end
                end
            end
            DRAIN: begin
                if (drain_cnt_q == '0) begin
                    state_d = DONE;
                end else begin
                    drain_cnt_d = drain_cnt_q - DRAIN_CNT_W'(1);
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (flush && (state_q != IDLE)) begin
            state_d     = IDLE;
            drain_cnt_d = '0;
        end

        sr_load  = accept;
        sr_shift = (state_d == SHIFT);
        sr_clear = (state_q != IDLE) && (state_d == IDLE);

        bit_idx_d = '0;
        if ((state_d == SHIFT) && (state_q == SHIFT)) begin
            bit_idx_d = bit_idx_q + IDX_W'(1);
        end

        ser_rst_d   = (state_d == CLEAR);
        ser_a_d     = (state_d == SHIFT) ? sr_a_lsb : 1'b0;
        ser_b_d     = (state_d == SHIFT) ? sr_b_lsb : 1'b0;
        ser_first_d = (state_d == SHIFT) && (bit_idx_d == '0);
        ser_last_d  = (state_d == SHIFT) && (bit_idx_d == LAST_IDX);

        ser_cin_d = 1'b0;
        if (accept) begin
            ser_cin_d = in_cin;
        end else if (state_d != IDLE) begin
            ser_cin_d = ser_cin_q;
        end

        busy_d = (state_d != IDLE);
        done_d = (state_d == DONE);
    end

    // State and output registers; reset returns to IDLE with everything low.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            drain_cnt_q <= '0;
            bit_idx_q   <= '0;
            ser_rst_q   <= 1'b0;
            ser_a_q     <= 1'b0;
            ser_b_q     <= 1'b0;
            ser_cin_q   <= 1'b0;
            ser_first_q <= 1'b0;
            ser_last_q  <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            drain_cnt_q <= drain_cnt_d;
            bit_idx_q   <= bit_idx_d;
            ser_rst_q   <= ser_rst_d;
            ser_a_q     <= ser_a_d;
            ser_b_q     <= ser_b_d;
            ser_cin_q   <= ser_cin_d;
            ser_first_q <= ser_first_d;
            ser_last_q  <= ser_last_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign ser_rst   = ser_rst_q;
    assign ser_a     = ser_a_q;
    assign ser_b     = ser_b_q;
    assign ser_cin   = ser_cin_q;
    assign ser_first = ser_first_q;
    assign ser_last  = ser_last_q;
    assign bit_idx   = bit_idx_q;
    assign busy      = busy_q;
    assign done      = done_q;

endmodule

// File: tb/tb_serial_operand_feeder.sv
// Scoreboard bench: two feeders (WIDTH=4/DRAIN=2 and WIDTH=8/DRAIN=0) checked
// cycle by cycle against a timeline model built from accept time and operands.
module tb_serial_operand_feeder;

    typedef struct {
        int         acc;
        logic [7:0] a;
        logic [7:0] b;
        logic       cin;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;

    logic       flush0 = 1'b0, inValid0 = 1'b0, inCin0 = 1'b0;
    logic [3:0] inA0 = '0, inB0 = '0;
    logic       inReady0, serRst0, serA0, serB0, serCin0, serFirst0, serLast0, busy0, done0;
    logic [1:0] bitIdx0;

    logic       flush1 = 1'b0, inValid1 = 1'b0, inCin1 = 1'b0;
    logic [7:0] inA1 = '0, inB1 = '0;
    logic       inReady1, serRst1, serA1, serB1, serCin1, serFirst1, serLast1, busy1, done1;
    logic [2:0] bitIdx1;

    exp_t       q0[$];
    exp_t       q1[$];
    int         abortEdge [2] = '{-1, -1};
    logic [7:0] gotA [2];
    logic [7:0] gotB [2];
    int         edgeCnt = 0;
    int         nVec = 0;
    int         nErr = 0;

    int         accX, accY, fa, inst;
    logic [7:0] ra, rb;
    logic       rc;
    bit         pair;

    serial_operand_feeder #(.WIDTH(4), .DRAIN_CYCLES(2)) dut0 (
        .clk(clk), .rst(rst), .flush(flush0), .in_valid(inValid0), .in_ready(inReady0),
        .in_a(inA0), .in_b(inB0), .in_cin(inCin0), .ser_rst(serRst0), .ser_a(serA0),
        .ser_b(serB0), .ser_cin(serCin0), .ser_first(serFirst0), .ser_last(serLast0),
        .bit_idx(bitIdx0), .busy(busy0), .done(done0)
    );

    serial_operand_feeder #(.WIDTH(8), .DRAIN_CYCLES(0)) dut1 (
        .clk(clk), .rst(rst), .flush(flush1), .in_valid(inValid1), .in_ready(inReady1),
        .in_a(inA1), .in_b(inB1), .in_cin(inCin1), .ser_rst(serRst1), .ser_a(serA1),
        .ser_b(serB1), .ser_cin(serCin1), .ser_first(serFirst1), .ser_last(serLast1),
        .bit_idx(bitIdx1), .busy(busy1), .done(done1)
    );

    // Free-running clock and an edge counter used as the shared time base.
    always #5 clk = ~clk;

    always @(posedge clk) edgeCnt++;

    function automatic int wOf(input int i);
        return (i == 0) ? 4 : 8;
    endfunction

    function automatic int dOf(input int i);
        return (i == 0) ? 2 : 0;
    endfunction

    function automatic logic [11:0] packOut(input logic bsy, input logic dn, input logic rdy,
                                            input logic srst, input logic cin, input logic a,
                                            input logic b, input logic first, input logic last,
                                            input logic [2:0] idx);
        return {bsy, dn, rdy, srst, cin, a, b, first, last, idx};
    endfunction

    function automatic logic [11:0] obsOf(input int i);
        if (i == 0)
            return packOut(busy0, done0, inReady0, serRst0, serCin0, serA0, serB0,
                           serFirst0, serLast0, {1'b0, bitIdx0});
        return packOut(busy1, done1, inReady1, serRst1, serCin1, serA1, serB1,
                       serFirst1, serLast1, bitIdx1);
    endfunction

    function automatic logic [11:0] idleOut(input logic fl);
        return packOut(1'b0, 1'b0, !fl, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0);
    endfunction

    function automatic bit frontOf(input int i, output exp_t e);
        e.acc = 0; e.a = '0; e.b = '0; e.cin = 1'b0;
        if (i == 0 && q0.size() > 0) begin e = q0[0]; return 1'b1; end
        if (i == 1 && q1.size() > 0) begin e = q1[0]; return 1'b1; end
        return 1'b0;
    endfunction

    task automatic popFront(input int i);
        if (i == 0) void'(q0.pop_front());
        else        void'(q1.pop_front());
    endtask

    task automatic compare(input string name, input int i, input logic [31:0] got,
                           input logic [31:0] expv);
        nVec++;
        if (got !== expv) begin
            nErr++;
            $display("[TB] FAIL %s inst%0d cycle %0d: got %h, expected %h",
                     name, i, edgeCnt, got, expv);
        end
    endtask

    // Reference timeline: relative to accept edge, cycle 0 clears, 1..W carry bits,
    // then DRAIN idle cycles, then one done cycle; everything else is idle.
    task automatic checkOutput(input int i);
        int         w, d, rel;
        exp_t       e;
        bit         have, active;
        logic [11:0] expv;
        logic       flIn, aObs, bObs, dObs;
        w    = wOf(i);
        d    = dOf(i);
        flIn = (i == 0) ? flush0 : flush1;
        aObs = (i == 0) ? serA0 : serA1;
        bObs = (i == 0) ? serB0 : serB1;
        dObs = (i == 0) ? done0 : done1;
        have = frontOf(i, e);
        if (have && abortEdge[i] >= 0 && edgeCnt >= abortEdge[i]) begin
            popFront(i);
            abortEdge[i] = -1;
            have = frontOf(i, e);
        end
        if (have && edgeCnt >= e.acc && (edgeCnt - e.acc) > w + d + 1) begin
            popFront(i);
            have = frontOf(i, e);
        end
        active = have && (edgeCnt >= e.acc);
        rel    = active ? (edgeCnt - e.acc) : 0;
        expv   = idleOut(flIn);
        if (active) begin
            if (rel == 0) begin
                expv = packOut(1'b1, 1'b0, 1'b0, 1'b1, e.cin, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0);
                gotA[i] = '0;
                gotB[i] = '0;
            end else if (rel <= w) begin
                expv = packOut(1'b1, 1'b0, 1'b0, 1'b0, e.cin, e.a[rel-1], e.b[rel-1],
                               rel == 1, rel == w, 3'(rel - 1));
                gotA[i][rel-1] = aObs;
                gotB[i][rel-1] = bObs;
            end else if (rel <= w + d) begin
                expv = packOut(1'b1, 1'b0, 1'b0, 1'b0, e.cin, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0);
            end else begin
                expv = packOut(1'b1, 1'b1, 1'b0, 1'b0, e.cin, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0);
            end
        end
        compare("cycle", i, 32'(obsOf(i)), 32'(expv));
        if (active && rel == w + d + 1 && dObs)
            compare("txn_bits", i, {16'h0, gotA[i], gotB[i]}, {16'h0, e.a, e.b});
    endtask

    // Monitor: samples registered outputs at the falling edge while out of reset.
    always @(negedge clk) begin
        if (!rst) begin
            checkOutput(0);
            checkOutput(1);
        end
    end

    task automatic driveData(input int i, input logic v, input logic [7:0] a,
                             input logic [7:0] b, input logic c);
        if (i == 0) begin inValid0 = v; inA0 = a[3:0]; inB0 = b[3:0]; inCin0 = c; end
        else        begin inValid1 = v; inA1 = a;      inB1 = b;      inCin1 = c; end
    endtask

    task automatic setFlush(input int i, input logic v);
        if (i == 0) flush0 = v;
        else        flush1 = v;
    endtask

    // Issues one request (entered at negedge+1), pushes the expected transaction on
    // acceptance, scrambles the inputs afterwards and optionally flushes mid-flight.
    task automatic applyStimulus(input int i, input logic [7:0] a, input logic [7:0] b,
                                 input logic c, input int flushAt, input bit keepValid,
                                 output int acc);
        exp_t e;
        bit   ok;
        acc = -1;
        ok  = 1'b0;
        driveData(i, 1'b1, a, b, c);
        for (int t = 0; t < 64 && !ok; t++) begin
            #1;
            if ((i == 0) ? inReady0 : inReady1) begin
                e.acc = edgeCnt + 1;
                e.a   = (i == 0) ? {4'h0, a[3:0]} : a;
                e.b   = (i == 0) ? {4'h0, b[3:0]} : b;
                e.cin = c;
                if (i == 0) q0.push_back(e);
                else        q1.push_back(e);
                acc = e.acc;
                ok  = 1'b1;
            end
            @(negedge clk); #1;
        end
        if (!ok) begin
            compare("accept_timeout", i, 32'd0, 32'd1);
            driveData(i, 1'b0, '0, '0, 1'b0);
            return;
        end
        driveData(i, keepValid, 8'($urandom), 8'($urandom), ~c);
        if (flushAt >= 0) begin
            while (edgeCnt < acc + flushAt) begin
                @(negedge clk); #1;
            end
            setFlush(i, 1'b1);
            abortEdge[i] = edgeCnt + 1;
            @(negedge clk); #1;
            setFlush(i, 1'b0);
        end
    endtask

    task automatic waitIdle(input int i);
        for (int t = 0; t < 64; t++) begin
            if (((i == 0) ? q0.size() : q1.size()) == 0) return;
            @(negedge clk); #1;
        end
        compare("idle_timeout", i, 32'd0, 32'd1);
    endtask

    // Asynchronous reset in mid-cycle; outputs must drop before any clock edge.
    task automatic resetMidCycle();
        #1;
        rst = 1'b1;
        #1;
        compare("reset_outputs", 0, 32'(obsOf(0)), 32'(idleOut(flush0)));
        compare("reset_outputs", 1, 32'(obsOf(1)), 32'(idleOut(flush1)));
        q0.delete();
        q1.delete();
        abortEdge[0] = -1;
        abortEdge[1] = -1;
        @(negedge clk); #2;
        rst = 1'b0;
        @(negedge clk); #1;
    endtask

    // Directed scenarios first, then a randomized mix across both feeders.
    initial begin
        @(negedge clk); #1;
        compare("reset_outputs", 0, 32'(obsOf(0)), 32'(idleOut(1'b0)));
        compare("reset_outputs", 1, 32'(obsOf(1)), 32'(idleOut(1'b0)));
        rst = 1'b0;
        repeat (4) begin @(negedge clk); #1; end

        applyStimulus(0, 8'h0B, 8'h06, 1'b0, -1, 1'b0, accX);
        waitIdle(0);

        applyStimulus(0, 8'h0F, 8'h00, 1'b1, -1, 1'b0, accX);
        waitIdle(0);

        applyStimulus(0, 8'h05, 8'h0A, 1'b1, -1, 1'b1, accX);
        applyStimulus(0, 8'h0C, 8'h03, 1'b0, -1, 1'b0, accY);
        compare("b2b_gap", 0, 32'(accY - accX), 32'd9);
        waitIdle(0);

        applyStimulus(0, 8'h09, 8'h07, 1'b1, 3, 1'b0, accX);
        waitIdle(0);
        driveData(0, 1'b1, 8'h03, 8'h03, 1'b1);
        setFlush(0, 1'b1);
        repeat (3) begin @(negedge clk); #1; end
        driveData(0, 1'b0, '0, '0, 1'b0);
        setFlush(0, 1'b0);
        @(negedge clk); #1;
        applyStimulus(0, 8'h06, 8'h09, 1'b0, -1, 1'b0, accX);
        waitIdle(0);

        applyStimulus(0, 8'h0E, 8'h0D, 1'b1, -1, 1'b0, accX);
        @(negedge clk); #1;
        resetMidCycle();
        repeat (3) begin @(negedge clk); #1; end

        applyStimulus(1, 8'hA5, 8'h3C, 1'b0, -1, 1'b0, accX);
        waitIdle(1);
        applyStimulus(1, 8'hFF, 8'h01, 1'b1, 5, 1'b0, accX);
        waitIdle(1);

        for (int n = 0; n < 30; n++) begin
            inst = int'($urandom_range(0, 1));
            ra   = 8'($urandom);
            rb   = 8'($urandom);
            rc   = 1'($urandom_range(0, 1));
            fa   = ($urandom_range(0, 4) == 0) ?
                   int'($urandom_range(0, wOf(inst) + dOf(inst))) : -1;
            pair = ($urandom_range(0, 2) == 0);
            applyStimulus(inst, ra, rb, rc, fa, pair, accX);
            if (pair)
                applyStimulus(inst, 8'($urandom), 8'($urandom), 1'($urandom_range(0, 1)),
                              -1, 1'b0, accY);
            waitIdle(inst);
        end

        repeat (3) begin @(negedge clk); #1; end
        $display("== %0d vectors applied, %0d miscompares ==", nVec, nErr);
        $finish;
    end

endmodule
